// File: rtl/axi4_qos_aw_arbiter.sv
// AW arbiter for one AXI4 slave port. It grants by QoS, breaks ties round-robin, and locks W routing until WLAST.
// The optional starvation aging is enabled when the AXI4_ARB_AGING_EN macro is defined.
module axi4_qos_aw_arbiter #(
  parameter int NUM_MASTERS = 8,
  parameter int QOS_WIDTH   = 4,
  parameter int IDX_WIDTH   = 3,
  parameter int AGE_WIDTH   = 8,
  parameter int AGE_LIMIT   = 64
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  input  logic [NUM_MASTERS-1:0]           req_valid,
  input  logic [NUM_MASTERS*QOS_WIDTH-1:0] req_qos,
  input  logic                             aw_hs,
  input  logic                             w_last_hs,
  output logic [NUM_MASTERS-1:0]           aw_grant,
  output logic                             aw_grant_vld,
  output logic [NUM_MASTERS-1:0]           w_sel,
  output logic                             w_sel_vld,
  output logic [IDX_WIDTH-1:0]             grant_idx,
  output logic                             busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  if (IDX_WIDTH != $clog2(NUM_MASTERS)) begin : g_idx_width_check
    $error("IDX_WIDTH must equal $clog2(NUM_MASTERS)");
  end
  if (AGE_LIMIT < 1 || AGE_LIMIT > (1 << AGE_WIDTH) - 1) begin : g_age_limit_check
    $error("AGE_LIMIT must be reachable by an AGE_WIDTH saturating counter");
  end

`ifdef AXI4_ARB_AGING_EN
  localparam int PRI_WIDTH = QOS_WIDTH + 1;
  localparam logic [AGE_WIDTH-1:0] AGE_THRESH = AGE_WIDTH'(AGE_LIMIT);
  logic [AGE_WIDTH-1:0] age [NUM_MASTERS];
`else
  localparam int PRI_WIDTH = QOS_WIDTH;
`endif

  state_t               state;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] rr_next;
  logic [PRI_WIDTH-1:0] eff_pri [NUM_MASTERS];
  logic [IDX_WIDTH-1:0] win_idx;
  logic [IDX_WIDTH-1:0] cand;
  logic [PRI_WIDTH-1:0] win_pri;
  logic                 win_found;
  logic [NUM_MASTERS-1:0] win_onehot;

  // An aged requester gets the extra top bit, so it outranks every unaged QoS value.
  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
`ifdef AXI4_ARB_AGING_EN
      eff_pri[i] = {age[i] >= AGE_THRESH, req_qos[i*QOS_WIDTH +: QOS_WIDTH]};
`else
      eff_pri[i] = req_qos[i*QOS_WIDTH +: QOS_WIDTH];
`endif
    end
  end

  // The scan starts at rr_ptr and uses a strict '>' compare, so the first equal-priority index after rr_ptr wins.
  // NOTE: every combinational output gets a default before the loop; otherwise a path that does not assign it infers a latch.
  always_comb begin
    win_idx   = '0;
    win_pri   = '0;
    win_found = 1'b0;
    cand      = '0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      cand = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_MASTERS);
      if (req_valid[cand] && (!win_found || eff_pri[cand] > win_pri)) begin
        win_idx   = cand;
        win_pri   = eff_pri[cand];
        win_found = 1'b1;
      end
    end
  end

  assign win_onehot = NUM_MASTERS'(1) << win_idx;
  assign rr_next    = (grant_idx == IDX_WIDTH'(NUM_MASTERS - 1)) ? '0 : grant_idx + 1'b1;

  // NOTE: sequential state uses non-blocking assignments so that every flop samples values from before the edge.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      rr_ptr       <= '0;
      aw_grant     <= '0;
      aw_grant_vld <= 1'b0;
      w_sel        <= '0;
      w_sel_vld    <= 1'b0;
      grant_idx    <= '0;
      busy         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state        <= ADDR;
            aw_grant     <= win_onehot;
            aw_grant_vld <= 1'b1;
            grant_idx    <= win_idx;
            busy         <= 1'b1;
          end
        end
        ADDR: begin
          // A WLAST that arrives together with the AW handshake is dropped. It must be seen again in DATA.
          if (aw_hs) begin
            state        <= DATA;
            aw_grant_vld <= 1'b0;
            w_sel        <= aw_grant;
            w_sel_vld    <= 1'b1;
            rr_ptr       <= rr_next;
          end
        end
        DATA: begin
          if (w_last_hs) begin
            state     <= IDLE;
            aw_grant  <= '0;
            w_sel     <= '0;
            w_sel_vld <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef AXI4_ARB_AGING_EN
  // Master i's counter holds while it owns the port. It clears when i wins arbitration or drops its request.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_MASTERS; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!req_valid[i] ||
            (state == IDLE && win_found && win_idx == IDX_WIDTH'(i))) begin
          age[i] <= '0;
        end else if (!(state != IDLE && grant_idx == IDX_WIDTH'(i)) && age[i] != '1) begin
          age[i] <= age[i] + 1'b1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_axi4_qos_aw_arbiter.sv
// Scoreboard bench for axi4_qos_aw_arbiter. A transaction-level model queues the expected AW and W owners.
// A monitor process pops those entries and compares them whenever the DUT raises a valid.
module tb_axi4_qos_aw_arbiter;
  localparam int N  = 8;
  localparam int QW = 4;
  localparam int IW = 3;
  localparam int AW = 8;
  localparam int AL = 4;

  logic            aclk = 1'b0;
  logic            aresetn;
  logic [N-1:0]    req_valid;
  logic [N*QW-1:0] req_qos;
  logic            aw_hs;
  logic            w_last_hs;
  logic [N-1:0]    aw_grant;
  logic            aw_grant_vld;
  logic [N-1:0]    w_sel;
  logic            w_sel_vld;
  logic [IW-1:0]   grant_idx;
  logic            busy;

  axi4_qos_aw_arbiter #(
    .NUM_MASTERS(N), .QOS_WIDTH(QW), .IDX_WIDTH(IW), .AGE_WIDTH(AW), .AGE_LIMIT(AL)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .req_valid(req_valid), .req_qos(req_qos),
    .aw_hs(aw_hs), .w_last_hs(w_last_hs), .aw_grant(aw_grant), .aw_grant_vld(aw_grant_vld),
    .w_sel(w_sel), .w_sel_vld(w_sel_vld), .grant_idx(grant_idx), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int m0_grants = 0;

  // Model state: phase 0 = idle, 1 = address granted, 2 = data locked.
  int m_phase = 0;
  int m_owner = 0;
  int m_rr    = 0;
`ifdef AXI4_ARB_AGING_EN
  int m_age [N];
`endif
  int exp_aw [$];
  int exp_w  [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick();
    int best = -1;
    int bp   = -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (req_valid[i]) begin
        int p = int'(req_qos[i*QW +: QW]);
`ifdef AXI4_ARB_AGING_EN
        if (m_age[i] >= AL) p += 16;
`endif
        if (p > bp) begin
          bp   = p;
          best = i;
        end
      end
    end
    return best;
  endfunction

  // Predicts the effect of the upcoming rising edge, based on the inputs that were just driven.
  function automatic void model_step();
    int win = -1;
    if (m_phase == 0 && req_valid != '0) win = pick();
`ifdef AXI4_ARB_AGING_EN
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] || i == win) m_age[i] = 0;
      else if (!(m_phase != 0 && i == m_owner) && m_age[i] < (1 << AW) - 1) m_age[i]++;
    end
`endif
    case (m_phase)
      0: if (win >= 0) begin m_phase = 1; m_owner = win; exp_aw.push_back(win); end
      1: if (aw_hs) begin m_phase = 2; m_rr = (m_owner + 1) % N; exp_w.push_back(m_owner); end
      default: if (w_last_hs) m_phase = 0;
    endcase
  endfunction

  function automatic void model_reset();
    m_phase = 0;
    m_owner = 0;
    m_rr    = 0;
`ifdef AXI4_ARB_AGING_EN
    for (int i = 0; i < N; i++) m_age[i] = 0;
`endif
    exp_aw.delete();
    exp_w.delete();
  endfunction

  task automatic step(input logic [N-1:0] rv, input logic [N*QW-1:0] q, input logic a, input logic w);
    @(negedge aclk);
    req_valid = rv;
    req_qos   = q;
    aw_hs     = a;
    w_last_hs = w;
    model_step();
  endtask

  task automatic settle();
    @(posedge aclk);
    #2;
  endtask

  // Monitor: compares the per-cycle phase, and pops the scoreboard entry on each rising valid.
  initial begin : monitor
    logic pv_aw, pv_w;
    int   e;
    pv_aw = 1'b0;
    pv_w  = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      if (aresetn) begin
        check("busy", busy, m_phase != 0);
        check("aw_grant_vld", aw_grant_vld, m_phase == 1);
        check("w_sel_vld", w_sel_vld, m_phase == 2);
        if (m_phase != 0) begin
          check("owner_grant", aw_grant, 64'(1) << m_owner);
          check("owner_idx", grant_idx, m_owner);
        end
        if (m_phase == 2) check("w_sel_lock", w_sel, 64'(1) << m_owner);
        else check("w_sel_clear", w_sel, 0);
        if (aw_grant_vld && !pv_aw) begin
          if (aw_grant[0]) m0_grants++;
          if (exp_aw.size() == 0) begin
            total++;
            bad++;
            $display("FAIL aw_sb: actual grant=%0h required none", aw_grant);
          end else begin
            e = exp_aw.pop_front();
            check("aw_sb_grant", aw_grant, 64'(1) << e);
            check("aw_sb_idx", grant_idx, e);
          end
        end
        if (w_sel_vld && !pv_w) begin
          if (exp_w.size() == 0) begin
            total++;
            bad++;
            $display("FAIL w_sb: actual w_sel=%0h required none", w_sel);
          end else begin
            e = exp_w.pop_front();
            check("w_sb_sel", w_sel, 64'(1) << e);
          end
        end
      end
      pv_aw = aw_grant_vld;
      pv_w  = w_sel_vld;
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [N-1:0]    rv;
    logic [N*QW-1:0] q;
    aresetn   = 1'b0;
    req_valid = '0;
    req_qos   = '0;
    aw_hs     = 1'b0;
    w_last_hs = 1'b0;
    #12;
    check("rst_aw_grant", aw_grant, 0);
    check("rst_aw_vld", aw_grant_vld, 0);
    check("rst_w_sel", w_sel, 0);
    check("rst_w_vld", w_sel_vld, 0);
    check("rst_idx", grant_idx, 0);
    check("rst_busy", busy, 0);
    @(negedge aclk);
    aresetn = 1'b1;

    // Test 1: all masters request at QoS 0. The first grant goes to m0, and m1 follows.
    step(8'hFF, '0, 0, 0); settle(); check("t1_grant", aw_grant, 8'h01);
    step(8'hFF, '0, 1, 0); settle(); check("t1_wsel", w_sel, 8'h01);
    step(8'hFF, '0, 0, 1); settle(); check("t1_idle", busy, 0);
    step(8'hFF, '0, 0, 0); settle(); check("t1_next", aw_grant, 8'h02);
    step('0, '0, 1, 0);
    step('0, '0, 0, 1);

    // Test 2: the higher QoS wins (m5 before m2).
    step(8'h24, 32'h0090_0300, 0, 0); settle(); check("t2_qos_win", grant_idx, 5);
    step(8'h24, 32'h0090_0300, 1, 0);
    step(8'h04, 32'h0000_0300, 0, 1);
    step(8'h04, 32'h0000_0300, 0, 0); settle(); check("t2_m2", grant_idx, 2);
    step('0, '0, 1, 0);
    step('0, '0, 0, 1);

    // Test 3: once granted, the grant is never revoked.
    step(8'h02, '0, 0, 0);
    step(8'h42, 32'h0F00_0000, 0, 0); settle(); check("t3_hold_addr", aw_grant, 8'h02);
    step(8'h42, 32'h0F00_0000, 1, 0); settle(); check("t3_hold_data", aw_grant, 8'h02);
    step(8'h42, 32'h0F00_0000, 0, 0); settle(); check("t3_wsel", w_sel, 8'h02);
    step(8'h42, 32'h0F00_0000, 0, 1);
    step('0, '0, 0, 0);

    // Test 4: rr_ptr wraps from 7 to 0 when two requesters tie.
    step(8'h40, '0, 0, 0);
    step('0, '0, 1, 0);
    step('0, '0, 0, 1);
    step(8'h88, 32'h4000_4000, 0, 0); settle(); check("t4_m7", grant_idx, 7);
    step(8'h88, 32'h4000_4000, 1, 0);
    step(8'h88, 32'h4000_4000, 0, 1);
    step(8'h88, 32'h4000_4000, 0, 0); settle(); check("t4_m3", grant_idx, 3);
    step('0, '0, 1, 0);
    step('0, '0, 0, 1);

    // Test 7: WLAST alone in ADDR is ignored. AW and WLAST together move the FSM to DATA only.
    step(8'h01, '0, 0, 0);
    step(8'h01, '0, 0, 1); settle(); check("t7_addr_hold", aw_grant_vld, 1);
    check("t7_no_w", w_sel_vld, 0);
    step('0, '0, 1, 1); settle(); check("t7_data", w_sel_vld, 1);
    step('0, '0, 0, 1); settle(); check("t7_idle", busy, 0);

    // Test 5: an asynchronous reset in the middle of DATA clears the outputs with no clock edge.
    step(8'h10, '0, 0, 0);
    step(8'h10, '0, 1, 0);
    step('0, '0, 0, 0);
    #2;
    aresetn = 1'b0;
    model_reset();
    #1;
    check("t5_aw_grant", aw_grant, 0);
    check("t5_w_sel", w_sel, 0);
    check("t5_w_vld", w_sel_vld, 0);
    check("t5_idx", grant_idx, 0);
    check("t5_busy", busy, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    step(8'hFF, '0, 0, 0); settle(); check("t5_rr_zero", grant_idx, 0);
    step('0, '0, 1, 0);
    step('0, '0, 0, 1);

    // Test 6: m0 requests at QoS 0 while m1 keeps requesting at QoS 15.
    m0_grants = 0;
    for (int c = 0; c < 40; c++) step(8'h03, 32'h0000_00F0, 1, 1);
    for (int c = 0; c < 4 && m_phase != 0; c++) step('0, '0, 1, 1);
    step('0, '0, 0, 0); settle();
`ifdef AXI4_ARB_AGING_EN
    check("t6_m0_aged_win", m0_grants != 0, 1);
`else
    check("t6_m0_starved", m0_grants, 0);
`endif

    // Randomized traffic. Narrow QoS values make round-robin ties frequent.
    for (int c = 0; c < 400; c++) begin
      rv = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      for (int i = 0; i < N; i++) q[i*QW +: QW] = QW'($urandom_range(0, 3));
      step(rv, q, $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 40);
    end

    for (int c = 0; c < 10 && m_phase != 0; c++) step('0, '0, 1, 1);
    step('0, '0, 0, 0); settle();
    check("drain_idle", busy, 0);
    check("sb_aw_empty", exp_aw.size(), 0);
    check("sb_w_empty", exp_w.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
